// File: rtl/timer_input_stage.sv
// Multi-channel external-clock input stage: synchroniser, glitch filter,
// edge selector and divide-by-(N+1) prescaler producing one-cycle count pulses.
module timer_input_stage #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 4,
  parameter int unsigned PS_W        = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        clk_ext,
  input  logic [NUM_CH-1:0]        en,
  input  logic [NUM_CH-1:0]        clr,
  input  logic [2*NUM_CH-1:0]      edge_sel,
  input  logic [FILT_W-1:0]        filt_len,
  input  logic [PS_W*NUM_CH-1:0]   ps_div,
  output logic [NUM_CH-1:0]        clk_pulse,
  output logic [NUM_CH-1:0]        glitch
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   flt;
    logic                   flt_d;
    logic [FILT_W-1:0]      fcnt;
    logic [PS_W-1:0]        pcnt;
    logic [PS_W-1:0]        div;
    logic [1:0]             sel;
    logic                   rise_c;
    logic                   fall_c;
    logic                   ev_c;
    logic                   pulse_q;
    logic                   glitch_q;

    assign s      = sync_q[SYNC_STAGES-1];
    assign sel    = edge_sel[2*i +: 2];
    assign div    = ps_div[PS_W*i +: PS_W];
    assign rise_c = flt & ~flt_d;
    assign fall_c = ~flt & flt_d;

    // Edge events come only from the filtered level, so edge_sel changes are glitch-free.
    always_comb begin
      ev_c = 1'b0;
      case (sel)
        2'b01:   ev_c = rise_c;
        2'b10:   ev_c = fall_c;
        2'b11:   ev_c = rise_c | fall_c;
        default: ev_c = 1'b0;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q   <= '0;
        flt      <= 1'b0;
        flt_d    <= 1'b0;
        fcnt     <= '0;
        glitch_q <= 1'b0;
        pcnt     <= '0;
        pulse_q  <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], clk_ext[i]};
        flt_d  <= flt;

        // Filter: level must mismatch filt_len+1 consecutive cycles to propagate.
        if (s == flt) begin
          fcnt     <= '0;
          glitch_q <= (fcnt != '0);
        end else if (fcnt == filt_len) begin
          flt      <= s;
          fcnt     <= '0;
          glitch_q <= 1'b0;
        end else begin
          fcnt     <= fcnt + FILT_W'(1);
          glitch_q <= 1'b0;
        end

        // Prescaler: >= compare makes a shrunk ps_div terminate on the next event.
        if (!en[i] || clr[i]) begin
          pcnt    <= '0;
          pulse_q <= 1'b0;
        end else if (ev_c && (pcnt >= div)) begin
          pcnt    <= '0;
          pulse_q <= 1'b1;
        end else if (ev_c) begin
          pcnt    <= pcnt + PS_W'(1);
          pulse_q <= 1'b0;
        end else begin
          pulse_q <= 1'b0;
        end
      end
    end

    assign clk_pulse[i] = pulse_q;
    assign glitch[i]    = glitch_q;
  end

endmodule

// File: tb/tb_timer_input_stage.sv
// Directed table-driven bench for timer_input_stage plus hand-written
// sequences for latency, ps_div change and asynchronous reset.
module tb_timer_input_stage;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned FILT_W = 4;
  localparam int unsigned PS_W   = 8;

  logic                   clk;
  logic                   rst;
  logic [NUM_CH-1:0]      clk_ext;
  logic [NUM_CH-1:0]      en;
  logic [NUM_CH-1:0]      clr;
  logic [2*NUM_CH-1:0]    edge_sel;
  logic [FILT_W-1:0]      filt_len;
  logic [PS_W*NUM_CH-1:0] ps_div;
  logic [NUM_CH-1:0]      clk_pulse;
  logic [NUM_CH-1:0]      glitch;

  timer_input_stage #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(2), .FILT_W(FILT_W), .PS_W(PS_W)
  ) dut (
    .clk(clk), .rst(rst), .clk_ext(clk_ext), .en(en), .clr(clr),
    .edge_sel(edge_sel), .filt_len(filt_len), .ps_div(ps_div),
    .clk_pulse(clk_pulse), .glitch(glitch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Free-running monitor: cumulative pulse/glitch counts and over-wide pulse count.
  int pc [NUM_CH];
  int gc [NUM_CH];
  int wide = 0;
  logic [NUM_CH-1:0] prev_p = '0;
  initial for (int k = 0; k < NUM_CH; k++) begin pc[k] = 0; gc[k] = 0; end
  always @(negedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (clk_pulse[k]) pc[k] = pc[k] + 1;
      if (glitch[k])    gc[k] = gc[k] + 1;
      if (clk_pulse[k] && prev_p[k]) wide = wide + 1;
    end
    prev_p = clk_pulse;
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct {
    string            name;
    logic [3:0]       en;
    logic [3:0]       clr;
    logic [7:0]       es;
    logic [7:0]       ps;
    logic [3:0]       filt;
    int               n;
    int               hi;
    int               lo;
    logic [3:0][7:0]  exp_p;
    logic [3:0][7:0]  exp_g;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic run_pattern(input int n, input int hi, input int lo, input logic [3:0] mask);
    for (int p = 0; p < n; p++) begin
      clk_ext = mask;
      repeat (hi) @(negedge clk);
      clk_ext = '0;
      repeat (lo) @(negedge clk);
    end
  endtask

  task automatic configure(input logic [3:0] e, input logic [7:0] es, input logic [7:0] ps,
                           input logic [3:0] fl, input logic [3:0] c);
    en       = e;
    edge_sel = es;
    ps_div   = {4{ps}};
    filt_len = fl;
    clr      = 4'hF;
    repeat (2) @(negedge clk);
    clr      = c;
    @(negedge clk);
  endtask

  // Raise clk_ext[ch] at a negedge; count posedges until clk_pulse[ch] is seen.
  task automatic measure(input int ch, output int cycles);
    clk_ext[ch] = 1'b1;
    cycles = 0;
    while (cycles < 50) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (clk_pulse[ch]) break;
    end
  endtask

  int base_p [NUM_CH];
  int base_g [NUM_CH];
  int lat;

  initial begin
    vecs[0] = '{"rise_div1",   4'hF, 4'h0, 8'b01_01_01_01, 8'd0, 4'd0, 10, 4, 4,
                {8'd10, 8'd10, 8'd10, 8'd10}, {8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[1] = '{"both_div5",   4'hF, 4'h0, 8'b11_11_11_11, 8'd4, 4'd0, 10, 4, 4,
                {8'd4, 8'd4, 8'd4, 8'd4}, {8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[2] = '{"ch_isolate",  4'b1101, 4'b0100, 8'b00_01_01_01, 8'd0, 4'd0, 10, 4, 4,
                {8'd0, 8'd0, 8'd0, 8'd10}, {8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[3] = '{"glitch_iso",  4'b1101, 4'b0100, 8'b00_01_01_01, 8'd0, 4'd3, 5, 3, 6,
                {8'd0, 8'd0, 8'd0, 8'd0}, {8'd5, 8'd5, 8'd5, 8'd5}};
    vecs[4] = '{"fall_div2",   4'hF, 4'h0, 8'b10_10_10_10, 8'd1, 4'd2, 8, 3, 3,
                {8'd4, 8'd4, 8'd4, 8'd4}, {8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[5] = '{"both_filt1",  4'hF, 4'h0, 8'b11_11_11_11, 8'd0, 4'd1, 6, 2, 2,
                {8'd12, 8'd12, 8'd12, 8'd12}, {8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[6] = '{"filt3_pass",  4'hF, 4'h0, 8'b01_01_01_01, 8'd0, 4'd3, 1, 4, 8,
                {8'd1, 8'd1, 8'd1, 8'd1}, {8'd0, 8'd0, 8'd0, 8'd0}};

    rst = 1'b1; clk_ext = '0; en = '0; clr = '0; edge_sel = '0; filt_len = '0; ps_div = '0;
    repeat (3) @(negedge clk);
    check("reset_pulse",  int'(clk_pulse), 0);
    check("reset_glitch", int'(glitch), 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven scenarios
    for (int v = 0; v < NV; v++) begin
      configure(vecs[v].en, vecs[v].es, vecs[v].ps, vecs[v].filt, vecs[v].clr);
      for (int k = 0; k < NUM_CH; k++) begin base_p[k] = pc[k]; base_g[k] = gc[k]; end
      run_pattern(vecs[v].n, vecs[v].hi, vecs[v].lo, 4'hF);
      repeat (20) @(negedge clk);
      for (int k = 0; k < NUM_CH; k++) begin
        check($sformatf("%s_pulse_ch%0d", vecs[v].name, k), pc[k] - base_p[k], int'(vecs[v].exp_p[k]));
        check($sformatf("%s_glitch_ch%0d", vecs[v].name, k), gc[k] - base_g[k], int'(vecs[v].exp_g[k]));
      end
    end

    // Latency with filt_len=0 and filt_len=3
    configure(4'hF, 8'b01_01_01_01, 8'd0, 4'd0, 4'h0);
    measure(0, lat);
    check("latency_filt0", lat, 4);
    @(negedge clk);
    check("pulse_width_filt0", int'(clk_pulse[0]), 0);
    clk_ext = '0;
    repeat (10) @(negedge clk);
    configure(4'hF, 8'b01_01_01_01, 8'd0, 4'd3, 4'h0);
    measure(0, lat);
    check("latency_filt3", lat, 7);
    clk_ext = '0;
    repeat (15) @(negedge clk);

    // Shrink ps_div from 9 to 2 after 7 counted edges
    configure(4'hF, 8'b01_01_01_01, 8'd9, 4'd0, 4'h0);
    base_p[0] = pc[0];
    run_pattern(7, 4, 4, 4'hF);
    repeat (10) @(negedge clk);
    check("psdiv9_no_pulse", pc[0] - base_p[0], 0);
    ps_div = {4{8'd2}};
    run_pattern(1, 4, 4, 4'hF);
    repeat (10) @(negedge clk);
    check("psdiv_shrink_pulse", pc[0] - base_p[0], 1);
    run_pattern(2, 4, 4, 4'hF);
    repeat (10) @(negedge clk);
    check("psdiv2_restart_hold", pc[0] - base_p[0], 1);
    run_pattern(1, 4, 4, 4'hF);
    repeat (10) @(negedge clk);
    check("psdiv2_third_edge", pc[0] - base_p[0], 2);

    // Asynchronous reset while a pulse is high
    configure(4'hF, 8'b01_01_01_01, 8'd0, 4'd0, 4'h0);
    measure(0, lat);
    check("pre_reset_pulse", int'(clk_pulse[0]), 1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_pulse",  int'(clk_pulse), 0);
    check("async_reset_glitch", int'(glitch), 0);
    clk_ext = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    measure(0, lat);
    check("latency_after_reset", lat, 4);
    clk_ext = '0;
    repeat (10) @(negedge clk);

    check("pulse_width_all", wide, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
